// File: rtl/acc_update_sequencer_if.sv
// rtl/acc_update_sequencer_if.sv - handshake bundle between the accumulator-update sequencer and its engines
//
// Purpose: groups the request/completion inputs and the phase-control outputs
// of acc_update_sequencer so they travel as one port.
// Signals:
//   start_in, iter_count       run request and iteration count
//   intt_done, ntt_done        engine completion indications
//   busy, done                 run status
//   intt_start, ntt_start      one-cycle engine start pulses
//   wr_en, wr_cycle            INTT-to-NTT writeaway enable and cycle index
//   mac_en                     key multiply/accumulate enable
//   iter_idx                   index of the active iteration
// Modports: slave = sequencer side, master = requester/engine side.
interface acc_update_sequencer_if #(
  parameter int ITER_WIDTH = 10,
  parameter int NTT_NUMBER = 4,
  parameter int CW         = 6
);
  logic                  start_in;
  logic [ITER_WIDTH-1:0] iter_count;
  logic                  intt_done;
  logic [NTT_NUMBER-1:0] ntt_done;
  logic                  busy;
  logic                  intt_start;
  logic                  ntt_start;
  logic                  wr_en;
  logic [CW-1:0]         wr_cycle;
  logic                  mac_en;
  logic [ITER_WIDTH-1:0] iter_idx;
  logic                  done;

  modport slave (
    input  start_in, iter_count, intt_done, ntt_done,
    output busy, intt_start, ntt_start, wr_en, wr_cycle, mac_en, iter_idx, done
  );

  modport master (
    output start_in, iter_count, intt_done, ntt_done,
    input  busy, intt_start, ntt_start, wr_en, wr_cycle, mac_en, iter_idx, done
  );
endinterface

// File: rtl/acc_update_sequencer.sv
// rtl/acc_update_sequencer.sv - phase sequencer for the accumulator-update loop
//
// Purpose: runs iter_count iterations of INTT -> writeaway drain -> NTT lanes
// -> key multiply/accumulate, issuing engine start pulses and phase enables.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    acc_update_sequencer_if.slave (requests/completions in, phase
//          control and status out)
// All outputs are decoded from registered state and counter only.
module acc_update_sequencer #(
  parameter int RING_DEPTH  = 10,
  parameter int PE_DEPTH    = 3,
  parameter int NTT_NUMBER  = 4,
  parameter int STAGE_DELAY = 8,
  parameter int ITER_WIDTH  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  acc_update_sequencer_if.slave bus
);
  localparam int RING_SIZE = 1 << RING_DEPTH;
  localparam int XFER      = RING_SIZE >> (PE_DEPTH + 1);
  localparam int L         = XFER + STAGE_DELAY;
  localparam int CW        = RING_DEPTH - PE_DEPTH - 1;
  localparam int CNT_W     = CW + 4;

  localparam logic [CNT_W-1:0] XFER_C = CNT_W'(XFER);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(L - 1);

  typedef enum logic [2:0] {
    IDLE,
    INTT_RUN,
    DRAIN,
    NTT_RUN,
    MAC,
    DONE
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cntr, cntr_nxt;
  logic [NTT_NUMBER-1:0] seen, seen_nxt;
  logic [ITER_WIDTH-1:0] iter_idx, iter_idx_nxt;
  logic [ITER_WIDTH-1:0] iter_total, iter_total_nxt;

  logic                  first_cycle;
  logic                  last_iter;
  logic [NTT_NUMBER-1:0] lanes_done;

  logic                  busy_d;
  logic                  intt_start_d;
  logic                  ntt_start_d;
  logic                  wr_en_d;
  logic [CW-1:0]         wr_cycle_d;
  logic                  mac_en_d;
  logic                  done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cntr       <= '0;
      seen       <= '0;
      iter_idx   <= '0;
      iter_total <= '0;
    end else begin
      state      <= state_nxt;
      cntr       <= cntr_nxt;
      seen       <= seen_nxt;
      iter_idx   <= iter_idx_nxt;
      iter_total <= iter_total_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cntr_nxt       = cntr;
    seen_nxt       = seen;
    iter_idx_nxt   = iter_idx;
    iter_total_nxt = iter_total;

    // In the two wait states cntr is parked at 1 after the entry cycle, so
    // cntr==0 marks the start-pulse cycle in which completions are ignored.
    first_cycle = (cntr == '0);
    last_iter   = (iter_idx == iter_total - ITER_WIDTH'(1));
    lanes_done  = seen | bus.ntt_done;

    busy_d       = (state != IDLE);
    intt_start_d = (state == INTT_RUN) && first_cycle;
    ntt_start_d  = (state == NTT_RUN) && first_cycle;
    wr_en_d      = (state == DRAIN) && (cntr < XFER_C);
    wr_cycle_d   = wr_en_d ? cntr[CW-1:0] : '0;
    mac_en_d     = (state == MAC) && (cntr < XFER_C);
    done_d       = (state == DONE);

    case (state)
      IDLE: begin
        if (bus.start_in) begin
          iter_total_nxt = bus.iter_count;
          iter_idx_nxt   = '0;
          cntr_nxt       = '0;
          state_nxt      = (bus.iter_count == '0) ? DONE : INTT_RUN;
        end
      end
      INTT_RUN: begin
        cntr_nxt = CNT_W'(1);
        if (!first_cycle && bus.intt_done) begin
          cntr_nxt  = '0;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cntr == LAST_C) begin
          cntr_nxt  = '0;
          state_nxt = NTT_RUN;
        end else begin
          cntr_nxt = cntr + CNT_W'(1);
        end
      end
      NTT_RUN: begin
        cntr_nxt = CNT_W'(1);
        if (first_cycle) begin
          // seen still holds the previous iteration's lanes here
          seen_nxt = '0;
        end else begin
          seen_nxt = lanes_done;
          if (&lanes_done) begin
            cntr_nxt  = '0;
            state_nxt = MAC;
          end
        end
      end
      MAC: begin
        if (cntr == LAST_C) begin
          cntr_nxt = '0;
          if (last_iter) begin
            state_nxt = DONE;
          end else begin
            iter_idx_nxt = iter_idx + ITER_WIDTH'(1);
            state_nxt    = INTT_RUN;
          end
        end else begin
          cntr_nxt = cntr + CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.busy       = busy_d;
  assign bus.intt_start = intt_start_d;
  assign bus.ntt_start  = ntt_start_d;
  assign bus.wr_en      = wr_en_d;
  assign bus.wr_cycle   = wr_cycle_d;
  assign bus.mac_en     = mac_en_d;
  assign bus.done       = done_d;
  assign bus.iter_idx   = iter_idx;
endmodule

// File: doc/acc_update_sequencer.md
# acc_update_sequencer

Top-level sequencer for the accumulator-update loop: INTT, then bit-reversed writeaway through the signed-digit decomposers into the NTT lanes, then the NTT lanes, then the secret-key multiply/accumulate phase.
It runs a programmable number of iterations per request and issues one-cycle start pulses to the engines.
It drives the writeaway cycle index and enables, and reports which iteration is active so the key-addressing logic can fetch the matching key.
It replaces the ad-hoc phase counter in the accumulator datapath and owns all phase timing.

## Interface
Parameters:
- RING_DEPTH, 10, log2 of ring size (RING_SIZE = 2^RING_DEPTH)
- PE_DEPTH, 3, log2 of PE count
- NTT_NUMBER, 4, number of NTT lanes (decomposition digits)
- STAGE_DELAY, 8, pipeline drain cycles appended to each transfer phase
- ITER_WIDTH, 10, width of iteration count/index

Derived values:
- XFER = RING_SIZE >> (PE_DEPTH+1), which is 64 at defaults
- L = XFER + STAGE_DELAY, which is 72 at defaults
- CW = RING_DEPTH-PE_DEPTH-1

Ports:
- clk, in, 1, clock; all logic on rising edge
- reset, in, 1, synchronous active-high reset
- start_in, in, 1, request a run; sampled only in IDLE
- iter_count, in, ITER_WIDTH, iterations for the run; latched when start is accepted
- intt_done, in, 1, INTT completion (level or pulse)
- ntt_done, in, NTT_NUMBER, per-lane NTT completion (level or pulse)
- busy, out, 1, high from the cycle after acceptance through the DONE cycle
- intt_start, out, 1, one-cycle INTT start pulse
- ntt_start, out, 1, one-cycle start pulse, shared by all NTT lanes
- wr_en, out, 1, INTT-to-NTT writeaway enable
- wr_cycle, out, CW, writeaway cycle index, fed to the bit reverser
- mac_en, out, 1, key multiply/accumulate enable
- iter_idx, out, ITER_WIDTH, index of the current iteration
- done, out, 1, one-cycle pulse at end of run

## Operation
- States: IDLE, INTT_RUN, DRAIN, NTT_RUN, MAC, DONE. There is one phase counter, cntr, of width CW+4.
- IDLE: accept when start_in=1.
  - If iter_count=0, go to DONE; no engine is started.
  - Otherwise go to INTT_RUN with iter_idx=0.
- INTT_RUN:
  - intt_start=1 on its first cycle only.
  - intt_done is ignored on that first cycle.
  - intt_done=1 on a later cycle moves the block to DRAIN with cntr=0.
- DRAIN: lasts exactly L cycles, with cntr counting 0..L-1.
  - wr_en=1 while cntr<XFER.
  - wr_cycle=cntr[CW-1:0] while wr_en=1; otherwise wr_cycle=0.
  - After cycle L-1, go to NTT_RUN.
- NTT_RUN:
  - ntt_start=1 on its first cycle only; this cycle also clears the sticky vector seen[NTT_NUMBER-1:0].
  - On every later cycle, seen |= ntt_done.
  - Move to MAC (cntr=0) on the first cycle in which (seen | ntt_done) is all ones. Lanes may finish on different cycles.
- MAC: lasts exactly L cycles.
  - mac_en=1 while cntr<XFER.
  - After the last MAC cycle, if iter_idx = iter_count_latched-1, go to DONE. Otherwise increment iter_idx and go to INTT_RUN.
- DONE: done=1 for one cycle, busy still 1. Next state is IDLE, where busy=0 and iter_idx holds its last value.
- start_in in any state other than IDLE is ignored and not queued. A change on iter_count after acceptance has no effect.
- Done inputs arriving outside their waiting state are ignored.
- iter_idx wraps only through the loop-exit compare. iter_count = 2^ITER_WIDTH-1 runs that many iterations.

## Timing
- Reset: state=IDLE; cntr=0, seen=0, iter_idx=0. All outputs are 0: busy, intt_start, ntt_start, wr_en, wr_cycle, mac_en, done.
- Reset asserted mid-run aborts immediately. The next cycle is IDLE with all outputs 0 and no done pulse.
- All outputs are registered (decoded from registered state and counter).
- Latency, with start accepted at cycle 0:
  - intt_start at cycle 1.
  - intt_done at cycle k (k≥2) gives DRAIN at k+1..k+L, with wr_en at k+1..k+XFER.
  - ntt_start at k+L+1.
  - Last lane done at cycle m gives MAC at m+1..m+L.
  - After MAC, either done at m+L+1 or the next intt_start at m+L+1.
- Minimum iteration length is 2L+4 cycles.

## Test plan
- Single iteration, defaults, iter_count=1, intt_done pulsed at cycle 6, all ntt_done pulsed at cycle 84:
  - intt_start @1
  - wr_en @7..70, with wr_cycle running 0..63
  - ntt_start @79
  - mac_en @85..148
  - done @157, busy low @158
- Staggered lanes: ntt_done bits pulsed singly at cycles +3, +5, +9, +20 after ntt_start -> MAC begins the cycle after the +20 pulse, and no earlier.
- iter_count=3 with immediate done responses -> exactly 3 intt_start and 3 ntt_start pulses, iter_idx 0,1,2, a single done; a second start_in asserted mid-run is ignored.
- iter_count=0 -> done one cycle after acceptance; no intt_start, wr_en or mac_en is ever asserted.
- Reset asserted during DRAIN at cntr=30 -> next cycle all outputs 0 and state IDLE; a fresh start then reproduces the first scenario's timing exactly.
- intt_done held high during the intt_start cycle only -> ignored; the FSM stays in INTT_RUN until intt_done rises again.
